serial_fa_ctrl: RTL
===================

# serial_fa_ctrl

Bit-serial adder controller that sequences a single one-bit full-adder cell across WIDTH-bit operands, one bit per clock, LSB first. The cell's carry is held in a flip-flop between cycles. A start/busy/done handshake is used, and the result is registered on completion. It sits between a register-file-style operand source and any consumer that can tolerate WIDTH-cycle arithmetic latency in exchange for minimal adder area.

## Interface
- WIDTH, 8, operand and result width in bits (≥2)
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE or DONE
- A  input  WIDTH  operand A; captured on accepted start
- B  input  WIDTH  operand B; captured on accepted start
- Cin  input  1  carry-in; captured on accepted start
- busy  output  1  high while bits are being processed
- done  output  1  one-cycle pulse; result valid
- Sum  output  WIDTH  registered result; held until next completion
- C_Out  output  1  registered final carry-out; held with Sum

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE/DONE with start=1:
  - load shift registers a_sr=A, b_sr=B, carry=Cin, cnt=0, s_sr=0
  - go to SHIFT
- SHIFT, each cycle:
  - compute (s,c) = fa(a_sr[0], b_sr[0], carry)
  - s_sr = {s, s_sr[WIDTH-1:1]}
  - a_sr and b_sr shift right with zero fill
  - carry = c, cnt = cnt+1
- When cnt reaches WIDTH-1 on an edge, that edge also does the following, then enters DONE:
  - Sum = final s_sr
  - C_Out = c
- DONE:
  - done=1 for exactly one cycle
  - no start: go to IDLE
  - start: behave as IDLE with start (back-to-back operation)
- start during SHIFT is ignored; no queuing.
- Operand inputs are don't-care except on the accepting edge.
- Sum/C_Out change only on the completion edge; partial results are never visible.
- cnt width is $clog2(WIDTH); there is no wrap beyond WIDTH-1.

## Timing
- Reset values: state=IDLE, busy=0, done=0, Sum=0, C_Out=0, all internal registers 0.
- Start accepted at edge k:
  - busy=1 from after edge k through edge k+WIDTH
  - Sum/C_Out update at edge k+WIDTH
  - done=1 in the cycle after edge k+WIDTH
- Latency: WIDTH+1 cycles from start edge to done high.
- Throughput: one result per WIDTH+1 cycles (back-to-back via DONE).
- busy and done are never both high.
- rst mid-SHIFT:
  - immediate return to reset values
  - the previous Sum/C_Out are lost (cleared to 0)
  - no done pulse
- Full-adder cell is combinational; the only registered path is carry → cell → carry.

## Configuration
- SERIAL_FA_SUB_EN defined:
  - adds input port sub (1 bit), captured with operands on an accepted start
  - sub=1 loads b_sr=~B and carry=1, ignoring Cin, so Sum=A−B mod 2^WIDTH
  - C_Out=1 means no borrow
  - sub=0 behaves as an add
- Undefined: no sub port; add only.

## Structure
- Package serial_fa_pkg:
  - state enum type (IDLE, SHIFT, DONE)
  - default WIDTH constant
- Sub-module fa_cell: purely combinational one-bit full adder (inputs a, b, ci; outputs s, co).
  - sum = a⊕b⊕ci
  - carry = (a·b)+((a⊕b)·ci)
  - Instantiated once.
- Controller holds the FSM, counter, shift registers and output registers.

## Test plan
- Basic add: WIDTH=8, A=0x5A, B=0x3C, Cin=0, start one cycle → done after 9 cycles, Sum=0x96, C_Out=0.
- Carry propagation:
  - A=0xFF, B=0x01, Cin=0 → Sum=0x00, C_Out=1
  - A=0xFF, B=0xFF, Cin=1 → Sum=0xFF, C_Out=1
- Ignored start: second start with A=0x01, B=0x01 issued 3 cycles into an operation → first result only, no extra done, busy never drops early.
- Back-to-back: start held high continuously → done pulses every 9 cycles, Sum updates each time, busy low only in DONE cycles.
- Reset mid-op: rst asserted at cycle 4 of SHIFT → busy=0, done=0, Sum=0, C_Out=0 immediately; next start completes normally.
- SERIAL_FA_SUB_EN:
  - sub=1, A=0x10, B=0x01 → Sum=0x0F, C_Out=1
  - sub=1, A=0x00, B=0x01 → Sum=0xFF, C_Out=0

Source files
------------

// File: rtl/serial_fa_pkg.sv
// Shared types and defaults for the bit-serial full-adder controller.
package serial_fa_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    localparam int unsigned DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_fa_ctrl_fa_cell.sv
// Purely combinational one-bit full adder, used as the serial adder's only arithmetic cell.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | ((a ^ b) & ci);

endmodule

// File: rtl/serial_fa_ctrl.sv
// Bit-serial adder controller: one fa_cell stepped LSB-first over WIDTH bits.
// Defining SERIAL_FA_SUB_EN adds a 'sub' input that turns the operation into A-B.
module serial_fa_ctrl
    import serial_fa_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
`ifdef SERIAL_FA_SUB_EN
    input  logic             sub,
`endif
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
    output logic             C_Out
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   s_q, s_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;

    logic               fa_s, fa_co;
    logic [WIDTH-1:0]   s_shift;
    logic [WIDTH-1:0]   b_load;
    logic               c_load;

    fa_cell u_fa (
        .a  (a_q[0]),
        .b  (b_q[0]),
        .ci (carry_q),
        .s  (fa_s),
        .co (fa_co)
    );

    // New sum bit enters at the MSB; after WIDTH steps the LSB has reached bit 0.
    assign s_shift = {fa_s, {(WIDTH-1){1'b0}}} | (s_q >> 1);

`ifdef SERIAL_FA_SUB_EN
    assign b_load = sub ? ~B : B;
    assign c_load = sub ? 1'b1 : Cin;
`else
    assign b_load = B;
    assign c_load = Cin;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d     = A;
                    b_d     = b_load;
                    carry_d = c_load;
                    cnt_d   = '0;
                    s_d     = '0;
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                s_d     = s_shift;
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                carry_d = fa_co;
                if (cnt_q == CNT_LAST) begin
                    sum_d   = s_shift;
                    cout_d  = fa_co;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign busy  = (state_q == SHIFT);
    assign done  = (state_q == DONE);
    assign Sum   = sum_q;
    assign C_Out = cout_q;

endmodule
